// File: rtl/demux_reg_n.sv
// ---------------------------------------------------------------------------
// demux_reg_n
//
// Registered one-to-N demultiplexer for the multiplier datapath.
// Each input word goes to the output channel selected by op. Every channel
// holds one word and has its own valid/ready handshake. A slow consumer
// therefore stalls only the words that are addressed to its channel.
//
// Parameters:
//   WIDTH     : data width of the input word and of each channel
//   N         : number of output channels (N >= 2)
//   SEL_W     : width of op (2**SEL_W >= N)
//   HOLD_LAST : 1 = a drained channel keeps its word, 0 = it clears to 0
//
// Ports:
//   clock      : rising-edge clock
//   reset      : synchronous, active-high reset
//   op         : destination channel index for the current word
//   entrada    : input data word
//   in_valid   : entrada/op are valid this cycle
//   in_ready   : word is accepted this cycle (combinational on op/out_ready)
//   out_data   : flattened channel data, channel k at [k*WIDTH +: WIDTH]
//   out_valid  : channel k holds an undelivered word
//   out_ready  : consumer of channel k takes its word this cycle
//   err        : one-cycle pulse after a word with op >= N is accepted
//   drop_count : saturating count of words dropped because op >= N
// ---------------------------------------------------------------------------
module demux_reg_n #(
  parameter int WIDTH     = 10,
  parameter int N         = 3,
  parameter int SEL_W     = 2,
  parameter int HOLD_LAST = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [SEL_W-1:0]   op,
  input  logic [WIDTH-1:0]   entrada,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [N*WIDTH-1:0] out_data,
  output logic [N-1:0]       out_valid,
  input  logic [N-1:0]       out_ready,
  output logic               err,
  output logic [7:0]         drop_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chan_state_e;

  chan_state_e state_q [N];
  chan_state_e state_d [N];

  logic [N-1:0] sel;
  logic [N-1:0] load;
  logic [N-1:0] drain;
  logic         op_hit;
  logic         drop;

  // Decode op into a one-hot channel select. An op value that matches no
  // channel leaves op_hit low, and that word is dropped.
  always_comb begin
    sel    = '0;
    op_hit = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (op == SEL_W'(k)) begin
        sel[k] = 1'b1;
        op_hit = 1'b1;
      end
    end
  end

  // The addressed channel can take a word when it is empty, or when it is
  // being drained in this same cycle. Out-of-range words are always taken,
  // so that a bad op can never deadlock the producer.
  always_comb begin
    in_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (sel[k]) begin
        in_ready = (state_q[k] == EMPTY) || out_ready[k];
      end
    end
  end

  // Per-channel load and drain strobes, and the drop strobe.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      out_valid[k] = (state_q[k] == FULL);
    end
    load  = sel & {N{in_valid && in_ready}};
    drain = out_valid & out_ready;
    drop  = in_valid && !op_hit;
  end

  // Next-state logic for each channel. A load wins over a drain, so a
  // channel that is loaded and drained in the same cycle stays FULL.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      state_d[k] = state_q[k];
      if (load[k]) begin
        state_d[k] = FULL;
      end else if (drain[k]) begin
        state_d[k] = EMPTY;
      end
    end
  end

  // State register for the channels.
  always_ff @(posedge clock) begin
    for (int k = 0; k < N; k++) begin
      if (reset) begin
        state_q[k] <= EMPTY;
      end else begin
        state_q[k] <= state_d[k];
      end
    end
  end

  // Channel data registers. A drained channel is cleared only when
  // HOLD_LAST is 0. A load in the same cycle takes priority.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_data <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (load[k]) begin
          out_data[k*WIDTH +: WIDTH] <= entrada;
        end else if (drain[k] && (HOLD_LAST == 0)) begin
          out_data[k*WIDTH +: WIDTH] <= '0;
        end
      end
    end
  end

  // Error pulse and saturating drop counter. Both update on the same edge
  // that accepts the bad word.
  always_ff @(posedge clock) begin
    if (reset) begin
      err        <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      err <= drop;
      if (drop && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_demux_reg_n.sv
// ---------------------------------------------------------------------------
// tb_demux_reg_n
//
// Self-checking bench for demux_reg_n. The bench drives two instances with
// the same stimulus: one with HOLD_LAST=1 and one with HOLD_LAST=0.
// A word is pushed into a scoreboard when it is driven. The scoreboard entry
// is popped when the word appears on its channel.
// ---------------------------------------------------------------------------
module tb_demux_reg_n;

  localparam int WIDTH = 10;
  localparam int N     = 3;
  localparam int SEL_W = 2;

  typedef struct {
    int               ch;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic               clock;
  logic               reset;
  logic [SEL_W-1:0]   op;
  logic [WIDTH-1:0]   entrada;
  logic               in_valid;
  logic [N-1:0]       out_ready;

  logic               in_ready;
  logic [N*WIDTH-1:0] out_data;
  logic [N-1:0]       out_valid;
  logic               err;
  logic [7:0]         drop_count;

  logic               in_ready_b;
  logic [N*WIDTH-1:0] out_data_b;
  logic [N-1:0]       out_valid_b;
  logic               err_b;
  logic [7:0]         drop_count_b;

  exp_t sb[$];
  int   total;
  int   bad;

  demux_reg_n #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W), .HOLD_LAST(1)) dut (
    .clock(clock), .reset(reset), .op(op), .entrada(entrada),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .err(err),
    .drop_count(drop_count)
  );

  demux_reg_n #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W), .HOLD_LAST(0)) dut_b (
    .clock(clock), .reset(reset), .op(op), .entrada(entrada),
    .in_valid(in_valid), .in_ready(in_ready_b), .out_data(out_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .err(err_b),
    .drop_count(drop_count_b)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Guard against a hung run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [WIDTH-1:0] chan(input logic [N*WIDTH-1:0] d, input int k);
    return d[k*WIDTH +: WIDTH];
  endfunction

  // Advance one edge, then settle away from the edge before sampling.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; op = '0; entrada = '0; out_ready = '0;
    step(); step();
    total++;
    if (out_valid !== 3'b000 || out_data !== '0 || err !== 1'b0 || drop_count !== 8'd0) begin
      bad++;
      $display("[TB] FAIL reset_state: got v=%b d=%h e=%b c=%0d, want all zero",
               out_valid, out_data, err, drop_count);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_fill();
    exp_t e;
    out_ready = '0;
    for (int i = 0; i < N; i++) begin
      op = SEL_W'(i); entrada = WIDTH'(2 * (i + 1)); in_valid = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("[TB] FAIL fill_ready ch%0d: got %b want 1", i, in_ready);
      end
      sb.push_back('{ch: i, data: WIDTH'(2 * (i + 1))});
      step();
    end
    in_valid = 1'b0;
    total++;
    if (out_valid !== 3'b111) begin
      bad++;
      $display("[TB] FAIL fill_valid: got %b want 111", out_valid);
    end
    for (int i = 0; i < N; i++) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("[TB] FAIL fill_sb: got empty scoreboard want entry");
      end else begin
        e = sb.pop_front();
        if (chan(out_data, e.ch) !== e.data) begin
          bad++;
          $display("[TB] FAIL fill_data ch%0d: got %0d want %0d", e.ch, chan(out_data, e.ch), e.data);
        end
      end
    end
    op = 2'd0; entrada = 10'd99; in_valid = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL fill_stall_ready: got %b want 0", in_ready);
    end
    step();
    in_valid = 1'b0;
    total++;
    if (chan(out_data, 0) !== 10'd2 || out_valid !== 3'b111) begin
      bad++;
      $display("[TB] FAIL fill_stall_data: got %0d/%b want 2/111", chan(out_data, 0), out_valid);
    end
  endtask

  task automatic test_stream();
    exp_t e;
    logic [WIDTH-1:0] vals [3] = '{10'd8, 10'd10, 10'd12};
    out_ready = 3'b010;
    for (int i = 0; i < 3; i++) begin
      op = 2'd1; entrada = vals[i]; in_valid = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("[TB] FAIL stream_ready %0d: got %b want 1", i, in_ready);
      end
      sb.push_back('{ch: 1, data: vals[i]});
      step();
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("[TB] FAIL stream_sb: got empty scoreboard want entry");
      end else begin
        e = sb.pop_front();
        if (out_valid[1] !== 1'b1 || chan(out_data, e.ch) !== e.data) begin
          bad++;
          $display("[TB] FAIL stream_data %0d: got v=%b d=%0d want v=1 d=%0d",
                   i, out_valid[1], chan(out_data, e.ch), e.data);
        end
      end
    end
    in_valid = 1'b0; out_ready = '0;
  endtask

  task automatic test_drop();
    int exp_cnt;
    op = 2'd3; entrada = 10'd5; in_valid = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL drop_ready: got %b want 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    exp_cnt = 1;
    total++;
    if (err !== 1'b1 || drop_count !== 8'(exp_cnt)) begin
      bad++;
      $display("[TB] FAIL drop_first: got err=%b cnt=%0d want err=1 cnt=1", err, drop_count);
    end
    total++;
    if (chan(out_data, 0) !== 10'd2 || chan(out_data, 1) !== 10'd12 ||
        chan(out_data, 2) !== 10'd6 || out_valid !== 3'b111) begin
      bad++;
      $display("[TB] FAIL drop_channels: got %0d/%0d/%0d v=%b want 2/12/6 v=111",
               chan(out_data, 0), chan(out_data, 1), chan(out_data, 2), out_valid);
    end
    step();
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL drop_pulse: got err=%b want 0", err);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      entrada = WIDTH'($urandom_range(0, 1023));
      step();
      if (exp_cnt < 255) exp_cnt++;
    end
    in_valid = 1'b0;
    total++;
    if (drop_count !== 8'(exp_cnt) || err !== 1'b1) begin
      bad++;
      $display("[TB] FAIL drop_saturate: got cnt=%0d err=%b want cnt=%0d err=1", drop_count, err, exp_cnt);
    end
    step();
    total++;
    if (drop_count !== 8'd255 || err !== 1'b0 || out_valid !== 3'b111) begin
      bad++;
      $display("[TB] FAIL drop_hold: got cnt=%0d err=%b v=%b want 255/0/111", drop_count, err, out_valid);
    end
  endtask

  task automatic test_hold_last();
    reset = 1'b1; step(); reset = 1'b0;
    op = 2'd0; entrada = 10'd9; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    total++;
    if (out_valid[0] !== 1'b1 || chan(out_data, 0) !== 10'd9 ||
        out_valid_b[0] !== 1'b1 || chan(out_data_b, 0) !== 10'd9) begin
      bad++;
      $display("[TB] FAIL hold_fill: got a=%b/%0d b=%b/%0d want 1/9 1/9",
               out_valid[0], chan(out_data, 0), out_valid_b[0], chan(out_data_b, 0));
    end
    out_ready = 3'b001;
    step();
    out_ready = '0;
    total++;
    if (out_valid[0] !== 1'b0 || chan(out_data, 0) !== 10'd9) begin
      bad++;
      $display("[TB] FAIL hold_keep: got v=%b d=%0d want v=0 d=9", out_valid[0], chan(out_data, 0));
    end
    total++;
    if (out_valid_b[0] !== 1'b0 || chan(out_data_b, 0) !== 10'd0) begin
      bad++;
      $display("[TB] FAIL hold_clear: got v=%b d=%0d want v=0 d=0", out_valid_b[0], chan(out_data_b, 0));
    end
  endtask

  task automatic test_independent();
    in_valid = 1'b1;
    op = 2'd0; entrada = 10'd3; step();
    op = 2'd1; entrada = 10'd11; step();
    op = 2'd2; entrada = 10'd7; out_ready = 3'b010;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL indep_ready: got %b want 1", in_ready);
    end
    step();
    in_valid = 1'b0; out_ready = '0;
    total++;
    if (out_valid !== 3'b101 || chan(out_data, 2) !== 10'd7 || chan(out_data, 0) !== 10'd3) begin
      bad++;
      $display("[TB] FAIL indep_state: got v=%b ch0=%0d ch2=%0d want v=101 ch0=3 ch2=7",
               out_valid, chan(out_data, 0), chan(out_data, 2));
    end
    op = 2'd0;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL indep_stalled: got %b want 0", in_ready);
    end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1;
    op = 2'd1; entrada = 10'd13; step();
    op = 2'd3; entrada = 10'd1; step();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 3'b111 || drop_count !== 8'd1) begin
      bad++;
      $display("[TB] FAIL rmid_pre: got v=%b cnt=%0d want v=111 cnt=1", out_valid, drop_count);
    end
    reset = 1'b1; in_valid = 1'b1; op = 2'd0; entrada = 10'd1; out_ready = '0;
    step();
    reset = 1'b0; in_valid = 1'b0;
    total++;
    if (out_valid !== 3'b000 || out_data !== '0 || drop_count !== 8'd0 || err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rmid_clear: got v=%b d=%h cnt=%0d err=%b want all zero",
               out_valid, out_data, drop_count, err);
    end
    step();
    total++;
    if (out_valid !== 3'b000 || chan(out_data, 0) !== 10'd0) begin
      bad++;
      $display("[TB] FAIL rmid_nostore: got v=%b ch0=%0d want v=000 ch0=0", out_valid, chan(out_data, 0));
    end
  endtask

  // Run the scenarios in order. Each scenario starts from the channel
  // contents that the previous one left behind.
  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1; op = '0; entrada = '0; in_valid = 1'b0; out_ready = '0;
    test_reset();
    test_fill();
    test_stream();
    test_drop();
    test_hold_last();
    test_independent();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
